mor1kx_spr_initiator: RTL and testbench

Single-outstanding SPR bus initiator: accepts read/write requests on a valid/ready request channel, drives one SPR bus access at a time toward SPR responders (PIC, tick timer, debug-visible units), waits for `spr_bus_ack`, and returns read data or an error on a valid/ready response channel. It sits between the debug/host bridge and the core's SPR bus, enabling SPR accesses without the pipeline.

---
 rtl/mor1kx_spr_initiator.sv | 137 +++++++++++++
 tb/tb_mor1kx_spr_initiator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_spr_initiator.sv
// Single-outstanding SPR bus initiator: valid/ready request -> one SPR access -> valid/ready response.
// Optional access timeout with error response when MOR1KX_SPR_INITIATOR_TIMEOUT_EN is defined.
module mor1kx_spr_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_q, state_d;
  logic        live_q;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept;
  logic        timeout;

  assign accept = (state_q == IDLE) && live_q && req_valid_i;

`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !spr_bus_ack_i && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdat_d  = req_dat_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (spr_bus_ack_i) begin
          rsp_dat_d = we_q ? 32'h0 : spr_dat_i;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (timeout) begin
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps req_ready_o low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 16'h0;
      wdat_q    <= 32'h0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE) && live_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign spr_access_o = (state_q == ACCESS);
  assign spr_we_o     = spr_access_o & we_q;
  assign spr_addr_o   = spr_access_o ? addr_q : 16'h0;
  assign spr_dat_o    = spr_access_o ? wdat_q : 32'h0;

endmodule

// File: tb/tb_mor1kx_spr_initiator.sv
// Self-checking bench for mor1kx_spr_initiator: directed cases plus randomized transactions.
module tb_mor1kx_spr_initiator;

`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [15:0] req_addr_i = 16'h0;
  logic [31:0] req_dat_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        spr_access_o;
  logic        spr_we_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_bus_ack_i;
  logic [31:0] spr_dat_i;

  int          checks = 0;
  int          passed = 0;
  int          fails = 0;

  // Responder model: acks in the (ack_delay+1)th access cycle; ack_delay < 0 never acks.
  int          ack_delay = -1;
  int          acc_cycles = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] rd_data = 32'h0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cycles <= 0;
    else acc_cycles <= spr_access_o ? acc_cycles + 1 : 0;
  end

  assign spr_bus_ack_i = stray_ack | (spr_access_o && ack_delay >= 0 && acc_cycles == ack_delay);
  assign spr_dat_i     = stray_ack ? 32'hDEAD_BEEF : (spr_bus_ack_i ? rd_data : ~rd_data);

  mor1kx_spr_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_dat_i    (req_dat_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_err_o    (rsp_err_o),
    .spr_access_o (spr_access_o),
    .spr_we_o     (spr_we_o),
    .spr_addr_o   (spr_addr_o),
    .spr_dat_o    (spr_dat_o),
    .spr_bus_ack_i(spr_bus_ack_i),
    .spr_dat_i    (spr_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready_o}, 32'h0);
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid_o}, 32'h0);
    chk({tag, "_rsp_dat"}, rsp_dat_o, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err_o}, 32'h0);
    chk({tag, "_spr_ctl"}, {14'h0, spr_access_o, spr_we_o, spr_addr_o}, 32'h0);
    chk({tag, "_spr_dat"}, spr_dat_o, 32'h0);
  endtask

  // One full transaction: request, access with expected length, response, optional backpressure.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                     input logic [31:0] rdat, input int d, input int hold, input bit stray);
    bit          exp_err;
    int          exp_cycles;
    logic [31:0] exp_dat;
    int          seen;
    int          n;
    exp_err    = TO_EN && (d < 0 || d >= TO);
    exp_cycles = exp_err ? TO : d + 1;
    exp_dat    = (exp_err || we) ? 32'h0 : rdat;

    @(negedge clk);
    chk("idle_ready", {31'h0, req_ready_o}, 32'h1);
    chk("idle_no_access", {31'h0, spr_access_o}, 32'h0);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_dat_i   = wdat;
    rd_data     = rdat;
    ack_delay   = d;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = ~we;
    req_addr_i  = 16'($urandom);
    req_dat_i   = $urandom;

    seen = 0;
    n    = 0;
    while (!rsp_valid_o && n < 400) begin
      @(negedge clk);
      n++;
      if (spr_access_o) begin
        seen++;
        chk("acc_we", {31'h0, spr_we_o}, {31'h0, we});
        chk("acc_addr", {16'h0, spr_addr_o}, {16'h0, addr});
        chk("acc_dat", spr_dat_o, wdat);
        chk("acc_ready_low", {31'h0, req_ready_o}, 32'h0);
      end
    end
    chk("rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
    chk("access_cycles", seen, exp_cycles);
    chk("rsp_latency", n, exp_cycles + 1);
    chk("rsp_dat", rsp_dat_o, exp_dat);
    chk("rsp_err", {31'h0, rsp_err_o}, {31'h0, exp_err});
    chk("resp_spr_ctl", {14'h0, spr_access_o, spr_we_o, spr_addr_o}, 32'h0);
    chk("resp_spr_dat", spr_dat_o, 32'h0);

    if (hold > 0) begin
      req_valid_i = 1'b1;
      req_addr_i  = 16'h1234;
      stray_ack   = stray;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'h0, rsp_valid_o}, 32'h1);
      chk("hold_dat", rsp_dat_o, exp_dat);
      chk("hold_err", {31'h0, rsp_err_o}, {31'h0, exp_err});
      chk("hold_ready_low", {31'h0, req_ready_o}, 32'h0);
      chk("hold_no_access", {31'h0, spr_access_o}, 32'h0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    stray_ack   = 1'b0;
    @(negedge clk);
    chk("post_ready", {31'h0, req_ready_o}, 32'h1);
    chk("post_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("post_no_access", {31'h0, spr_access_o}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    stray_ack = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_stray_ack");
    stray_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release_ready_not_yet", {31'h0, req_ready_o}, 32'h0);
    @(negedge clk);
    chk("release_ready", {31'h0, req_ready_o}, 32'h1);
    chk("release_no_access", {31'h0, spr_access_o}, 32'h0);

    // Ack in IDLE must not start anything.
    stray_ack = 1'b1;
    @(negedge clk);
    chk("idle_stray_no_access", {31'h0, spr_access_o}, 32'h0);
    stray_ack = 1'b0;

    txn(1'b0, 16'h4800, 32'h0, 32'h0000_0003, 0, 0, 1'b0);
    txn(1'b1, 16'h4802, 32'hFFFF_0000, 32'h1234_5678, 3, 0, 1'b0);
    if (TO_EN) begin
      txn(1'b0, 16'h5000, 32'h0, 32'hAAAA_5555, -1, 0, 1'b0);
      txn(1'b0, 16'h5000, 32'h0, 32'h0000_0055, 3, 0, 1'b0);
      txn(1'b1, 16'h5001, 32'h0BAD_F00D, 32'h0, 4, 1, 1'b0);
    end
    txn(1'b0, 16'h4801, 32'h0, 32'hCAFE_0001, 1, 5, 1'b1);

    // Reset during the second access cycle.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 16'h2800;
    req_dat_i   = 32'h1111_2222;
    ack_delay   = -1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("midrst_access_1st", {31'h0, spr_access_o}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
      chk("midrst_no_access", {31'h0, spr_access_o}, 32'h0);
    end
    txn(1'b0, 16'h2801, 32'h0, 32'h7777_0000, 2, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int d;
      d = $urandom_range(0, 6);
      if (TO_EN && $urandom_range(0, 3) == 0) d = -1;
      txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom, d,
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
